// File: rtl/signed_kernel_accum.sv
// -----------------------------------------------------------------------------
// signed_kernel_accum
//
// Handshaked signed accumulator that sums one frame of TERMS operands. Each
// operand can be doubled and/or negated on acceptance, so a single frame
// evaluates one Sobel-style kernel window (Gx or Gy). It sits between the
// window buffer and the gradient magnitude stage.
//
// Optional feature macro: SIGNED_KERNEL_ACCUM_SAT_EN
//   defined   : out_pix is out_sum clamped to the OUT_W signed range and
//               out_sat flags a clamp.
//   undefined : out_pix is the low OUT_W bits of out_sum (wrap) and
//               out_sat is tied to 0.
//
// Ports
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   clear      synchronous frame abort (discards partial frame / pending result)
//   in_valid   operand valid
//   in_ready   block can accept an operand this cycle (state ACCUM)
//   in_data    signed operand, IN_W bits
//   in_neg     negate the operand before adding
//   in_shl     multiply the operand by 2 before adding
//   out_valid  frame result valid (state DONE)
//   out_ready  consumer accepts the result
//   out_sum    signed full-precision frame sum, SUM_W bits
//   out_pix    signed pixel-width result, OUT_W bits
//   out_sat    out_pix was clamped
// -----------------------------------------------------------------------------
module signed_kernel_accum #(
   parameter  int IN_W  = 8,
   parameter  int TERMS = 9,
   parameter  int OUT_W = 8,
   localparam int SUM_W = IN_W + 2 + $clog2(TERMS)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_neg,
   input  logic                    in_shl,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [SUM_W-1:0] out_sum,
   output logic signed [OUT_W-1:0] out_pix,
   output logic                    out_sat
);

   localparam int               CNT_W    = $clog2(TERMS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nx_s;
   logic signed [SUM_W-1:0] acc_r;
   logic [CNT_W-1:0]        count_r;
   logic signed [SUM_W-1:0] term_s;
   logic signed [SUM_W-1:0] sum_nx_s;
   logic signed [OUT_W-1:0] pix_nx_s;
   logic                    accept_s;
   logic                    last_s;

   // Sign-extend to full precision first so doubling and negating the most
   // negative operand cannot wrap (SUM_W leaves two spare headroom bits).
   function automatic logic signed [SUM_W-1:0] form_term(
      input logic signed [IN_W-1:0] data,
      input logic                   neg,
      input logic                   shl
   );
      logic signed [SUM_W-1:0] t;
      t = SUM_W'(data);
      if (shl) begin
         t = t <<< 1;
      end else begin
         t = t;
      end
      if (neg) begin
         t = -t;
      end else begin
         t = t;
      end
      return t;
   endfunction

   assign term_s   = form_term(in_data, in_neg, in_shl);
   assign sum_nx_s = acc_r + term_s;
   // clear discards any operand presented in the same cycle
   assign accept_s = in_valid && in_ready && !clear;
   assign last_s   = (count_r == LAST_CNT);

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic and handshake outputs decoded from the state register
   always_comb begin
      state_nx_s = state_r;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_r)
         ACCUM: begin
            in_ready = 1'b1;
            if (clear) begin
               state_nx_s = ACCUM;
            end else if (accept_s && last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = ACCUM;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // clear together with out_ready also counts as consumption
            if (clear || out_ready) begin
               state_nx_s = ACCUM;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = ACCUM;
         end
      endcase
   end

   // Running partial sum and operand counter for the current frame
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc_r   <= '0;
         count_r <= '0;
      end else if (clear) begin
         acc_r   <= '0;
         count_r <= '0;
      end else if (accept_s) begin
         if (last_s) begin
            acc_r   <= '0;
            count_r <= '0;
         end else begin
            acc_r   <= sum_nx_s;
            count_r <= count_r + CNT_W'(1);
         end
      end else begin
         acc_r   <= acc_r;
         count_r <= count_r;
      end
   end

`ifdef SIGNED_KERNEL_ACCUM_SAT_EN
   localparam logic signed [SUM_W-1:0] PIX_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] PIX_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic sat_nx_s;

   // Clamp the completed sum into the pixel range
   always_comb begin
      pix_nx_s = sum_nx_s[OUT_W-1:0];
      sat_nx_s = 1'b0;
      if (sum_nx_s > PIX_MAX) begin
         pix_nx_s = PIX_MAX[OUT_W-1:0];
         sat_nx_s = 1'b1;
      end else if (sum_nx_s < PIX_MIN) begin
         pix_nx_s = PIX_MIN[OUT_W-1:0];
         sat_nx_s = 1'b1;
      end else begin
         sat_nx_s = 1'b0;
      end
   end

   // Saturation flag, loaded together with the frame result
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_sat <= 1'b0;
      end else if (accept_s && last_s) begin
         out_sat <= sat_nx_s;
      end else begin
         out_sat <= out_sat;
      end
   end
`else
   // Pixel output simply wraps to OUT_W bits
   assign pix_nx_s = sum_nx_s[OUT_W-1:0];
   assign out_sat  = 1'b0;
`endif

   // Result registers: only a frame completion or reset changes them
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_sum <= '0;
         out_pix <= '0;
      end else if (accept_s && last_s) begin
         out_sum <= sum_nx_s;
         out_pix <= pix_nx_s;
      end else begin
         out_sum <= out_sum;
         out_pix <= out_pix;
      end
   end

endmodule

// File: tb/tb_signed_kernel_accum.sv
// -----------------------------------------------------------------------------
// tb_signed_kernel_accum
//
// Self-checking bench for signed_kernel_accum (IN_W=4, TERMS=9, OUT_W=8).
// A frame-level reference model (integer sums, a pending-result flag) predicts
// in_ready, out_valid and the result registers every cycle. Directed frames
// cover the worked examples; a randomized phase mixes gaps, backpressure and
// clears. Build with +define+SIGNED_KERNEL_ACCUM_SAT_EN for the clamp variant.
// -----------------------------------------------------------------------------
module tb_signed_kernel_accum;

   localparam int IN_W  = 4;
   localparam int TERMS = 9;
   localparam int OUT_W = 8;
   localparam int SUM_W = IN_W + 2 + $clog2(TERMS);

   logic                    clk;
   logic                    n_rst;
   logic                    clear;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    in_neg;
   logic                    in_shl;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [SUM_W-1:0] out_sum;
   logic signed [OUT_W-1:0] out_pix;
   logic                    out_sat;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_acc;
   int m_cnt;
   int m_sum;
   bit m_pend;

   signed_kernel_accum #(.IN_W(IN_W), .TERMS(TERMS), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_neg    (in_neg),
      .in_shl    (in_shl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_pix   (out_pix),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pix_of(input int s);
      int w;
`ifdef SIGNED_KERNEL_ACCUM_SAT_EN
      if (s > 127) w = 127;
      else if (s < -128) w = -128;
      else w = s;
`else
      w = s & 255;
      if (w > 127) w = w - 256;
`endif
      return w;
   endfunction

   function automatic int sat_of(input int s);
`ifdef SIGNED_KERNEL_ACCUM_SAT_EN
      return (s > 127 || s < -128) ? 1 : 0;
`else
      return (s == s + 1) ? 1 : 0;
`endif
   endfunction

   task automatic model_reset();
      m_acc  = 0;
      m_cnt  = 0;
      m_sum  = 0;
      m_pend = 1'b0;
   endtask

   task automatic check_outputs(input string pfx);
      check_val({pfx, "_out_valid"}, {31'd0, out_valid}, {31'd0, m_pend});
      check_val({pfx, "_out_sum"}, out_sum, m_sum);
      check_val({pfx, "_out_pix"}, out_pix, pix_of(m_sum));
      check_val({pfx, "_out_sat"}, {31'd0, out_sat}, sat_of(m_sum));
   endtask

   // One clock cycle: drive at negedge, predict, compare after the rising edge
   task automatic step(input logic v, input logic signed [IN_W-1:0] d, input logic ng,
                       input logic sh, input logic ordy, input logic clr);
      bit acc_now;
      int t;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_neg    = ng;
      in_shl    = sh;
      out_ready = ordy;
      clear     = clr;
      #1;
      check_val("in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
      acc_now = v && !m_pend && !clr;
      @(posedge clk);
      if (clr) begin
         m_pend = 1'b0;
         m_acc  = 0;
         m_cnt  = 0;
      end else if (m_pend) begin
         if (ordy) m_pend = 1'b0;
      end else if (acc_now) begin
         t = d;
         if (sh) t = t * 2;
         if (ng) t = -t;
         if (m_cnt == TERMS - 1) begin
            m_sum  = m_acc + t;
            m_pend = 1'b1;
            m_acc  = 0;
            m_cnt  = 0;
         end else begin
            m_acc = m_acc + t;
            m_cnt = m_cnt + 1;
         end
      end
      #1;
      check_outputs("cyc");
   endtask

   task automatic feed(input int n, input logic signed [IN_W-1:0] d, input logic ng,
                       input logic sh, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b1, d, ng, sh, ordy, 1'b0);
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear at once
   task automatic async_reset();
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      model_reset();
      check_outputs("rst");
      check_val("rst_in_ready", {31'd0, in_ready}, 32'sd1);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      in_neg = 1'b0; in_shl = 1'b0; out_ready = 1'b0;
      model_reset();
      #3;
      check_outputs("init");
      check_val("init_in_ready", {31'd0, in_ready}, 32'sd1);
      @(negedge clk);
      n_rst = 1'b1;

      // nine plain -6 operands
      feed(9, 4'sb1010, 1'b0, 1'b0, 1'b1);
      check_val("m6_sum", out_sum, -32'sd54);
      check_val("m6_pix", out_pix, -32'sd54);
      check_val("m6_bubble", {31'd0, in_ready}, 32'sd0);
      step(1'b1, 4'sd1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("m6_ready_back", {31'd0, in_ready}, 32'sd1);

      // most negative operand, negated and doubled: +16 each
      feed(9, 4'sb1000, 1'b1, 1'b1, 1'b1);
      check_val("edge_sum", out_sum, 32'sd144);
`ifdef SIGNED_KERNEL_ACCUM_SAT_EN
      check_val("edge_pix", out_pix, 32'sd127);
      check_val("edge_sat", {31'd0, out_sat}, 32'sd1);
`else
      check_val("edge_pix", out_pix, -32'sd112);
      check_val("edge_sat", {31'd0, out_sat}, 32'sd0);
`endif
      step(1'b0, 4'sd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // backpressure: result held, input pulses ignored
      feed(9, 4'sd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, IN_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("bp_hold_sum", out_sum, 32'sd27);
      check_val("bp_hold_valid", {31'd0, out_valid}, 32'sd1);
      step(1'b0, 4'sd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("bp_release", {31'd0, out_valid}, 32'sd0);

      // gaps then clear, then a full frame of +1
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'sd7, 1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 4'sd7, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      step(1'b1, 4'sd7, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("clr_no_result", {31'd0, out_valid}, 32'sd0);
      feed(9, 4'sd1, 1'b0, 1'b0, 1'b1);
      check_val("clr_sum", out_sum, 32'sd9);
      step(1'b0, 4'sd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // async reset mid-frame and while a result is pending
      feed(5, 4'sd2, 1'b0, 1'b0, 1'b1);
      async_reset();
      feed(9, 4'sd1, 1'b0, 1'b0, 1'b0);
      check_val("pre_rst_valid", {31'd0, out_valid}, 32'sd1);
      async_reset();
      feed(9, 4'sd1, 1'b0, 1'b0, 1'b1);
      check_val("post_rst_sum", out_sum, 32'sd9);

      // randomized traffic with backpressure and occasional clears
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
              IN_W'($urandom),
              1'($urandom), 1'($urandom),
              ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
